// File: rtl/dmem_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_uart_pkg
// Description : Shared types and helpers for the data-memory to UART
//               transmit streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_uart_pkg;

    // Streamer control states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_SEND     = 3'd4,
        ST_WAIT_ACK = 3'd5,
        ST_DONE     = 3'd6
    } streamer_state_t;

    // Number of UART bytes needed to carry one memory word (rounded up)
    function automatic int bytes_per_word(input int word_w, input int byte_w);
        return (word_w + byte_w - 1) / byte_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_uart_streamer_shifter.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_shifter
// Description : Holds one memory word, zero-padded up to a whole number of
//               bytes, and presents it LSB byte first. Tracks which byte of
//               the word is current and flags the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_shifter #(
    parameter int WORD_W = 24,
    parameter int BYTE_W = 8,
    parameter int BYTES  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_word,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_last_byte
);

    localparam int SHIFT_W = BYTES * BYTE_W;
    localparam int CNT_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [SHIFT_W-1:0] w_padded;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_byte_cnt;

    // Top bits above the word are filled with zeros when the word is not a
    // whole number of bytes.
    generate
        if (SHIFT_W > WORD_W) begin : g_pad
            assign w_padded = {{(SHIFT_W - WORD_W){1'b0}}, i_word};
        end else begin : g_nopad
            assign w_padded = i_word;
        end
    endgenerate

    // Parallel load of a fresh word, or step to the next byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= w_padded;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_shift    <= r_shift >> BYTE_W;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign o_byte      = r_shift[BYTE_W-1:0];
    assign o_last_byte = (r_byte_cnt == CNT_W'(BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/dmem_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_uart_streamer
// Description : Reads an inclusive range of data memory and streams each
//               word to the UART transmitter as bytes, LSB first, using a
//               ready/start handshake. Raises a sticky done flag at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_uart_streamer
    import dmem_uart_pkg::*;
#(
    parameter int MEM_WORD_LENGTH = 24,
    parameter int MEM_DEPTH       = 4096,
    parameter int UART_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       txStartN,
    input  logic [$clog2(MEM_DEPTH)-1:0] start_addr,
    input  logic [$clog2(MEM_DEPTH)-1:0] end_addr,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_address,
    input  logic [MEM_WORD_LENGTH-1:0] dataFromMem,
    input  logic                       txByteReady,
    output logic                       txByteStart,
    output logic [UART_WIDTH-1:0]      byteForTx,
    output logic                       busy,
    output logic                       mem_transmitted
);

    localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH);
    localparam int BYTES_PER_WORD = bytes_per_word(MEM_WORD_LENGTH, UART_WIDTH);

    streamer_state_t        r_state;
    logic [ADDR_WIDTH-1:0]  r_mem_address;
    logic [ADDR_WIDTH-1:0]  r_end_addr;
    logic [UART_WIDTH-1:0]  r_byte;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_load;
    logic                   w_shift;
    logic                   w_last_byte;
    logic [UART_WIDTH-1:0]  w_cur_byte;

    // Word capture happens once the registered RAM has produced the data;
    // the shift happens only when tx has accepted a non-final byte.
    assign w_load  = (r_state == ST_LOAD);
    assign w_shift = (r_state == ST_WAIT_ACK) && !txByteReady && !w_last_byte;

    word_byte_shifter #(
        .WORD_W (MEM_WORD_LENGTH),
        .BYTE_W (UART_WIDTH),
        .BYTES  (BYTES_PER_WORD)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_word      (dataFromMem),
        .o_byte      (w_cur_byte),
        .o_last_byte (w_last_byte)
    );

    // Transfer sequencing with registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mem_address <= '0;
            r_end_addr    <= '0;
            r_byte        <= '0;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!txStartN) begin
                        r_end_addr <= end_addr;
                        r_done     <= 1'b0;
                        if (end_addr < start_addr) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_address <= start_addr;
                            r_busy        <= 1'b1;
                            r_state       <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (txByteReady) begin
                        r_tx_start <= 1'b1;
                        r_byte     <= w_cur_byte;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_tx_start <= 1'b0;
                    r_state    <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // Ready dropping low is the transmitter's acceptance
                    if (!txByteReady) begin
                        if (!w_last_byte) begin
                            r_state <= ST_WAIT_RDY;
                        end else if (r_mem_address == r_end_addr) begin
                            // Compared before incrementing so the top
                            // address never wraps around.
                            r_state <= ST_DONE;
                        end else begin
                            r_mem_address <= r_mem_address + ADDR_WIDTH'(1);
                            r_state       <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_address     = r_mem_address;
    assign byteForTx       = r_byte;
    assign txByteStart     = r_tx_start;
    assign busy            = r_busy;
    assign mem_transmitted = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_uart_streamer
// Description : Self-checking bench for dmem_uart_streamer with a registered
//               RAM model, a UART tx ready model and a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_uart_streamer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          txStartN;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [AW-1:0] mem_address;
    logic [23:0]   dataFromMem;
    logic          txByteReady;
    logic          txByteStart;
    logic [7:0]    byteForTx;
    logic          busy;
    logic          mem_transmitted;

    logic [23:0]   mem [0:4095];
    logic [7:0]    exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            pulses   = 0;
    int            base     = 0;
    bit            tx_hold  = 1'b0;
    int            tx_cnt   = 0;

    dmem_uart_streamer dut (
        .clk             (clk),
        .rst             (rst),
        .txStartN        (txStartN),
        .start_addr      (start_addr),
        .end_addr        (end_addr),
        .mem_address     (mem_address),
        .dataFromMem     (dataFromMem),
        .txByteReady     (txByteReady),
        .txByteStart     (txByteStart),
        .byteForTx       (byteForTx),
        .busy            (busy),
        .mem_transmitted (mem_transmitted)
    );

    always #5 clk = ~clk;

    // Registered RAM: data follows the address by one clock
    always @(posedge clk) dataFromMem <= mem[mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each start pulse must match the next expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && txByteStart) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got byte 0x%0h expected no pulse", byteForTx);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", {24'h0, byteForTx}, {24'h0, e});
            end
        end
    end

    // UART tx model: busy for 3 cycles after each start pulse, or held busy
    initial begin
        txByteReady = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_cnt      = 0;
                txByteReady = !tx_hold;
            end else if (txByteStart) begin
                tx_cnt      = 3;
                txByteReady = 1'b0;
            end else begin
                if (tx_cnt > 0) tx_cnt--;
                txByteReady = !tx_hold && (tx_cnt == 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
    endtask

    // Drive a one-cycle start request; returns just after the sampling edge
    task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] e);
        @(negedge clk);
        start_addr = s;
        end_addr   = e;
        txStartN   = 1'b0;
        @(negedge clk);
        txStartN   = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(mem_transmitted && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {31'h0, (mem_transmitted && !busy)}, 32'h1);
        check({name, "_queue_empty"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_pulses(input string name, input int target, input int budget);
        int n = 0;
        while (pulses < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, (pulses >= target)}, 32'h1);
    endtask

    initial begin
        rst        = 1'b1;
        txStartN   = 1'b1;
        start_addr = '0;
        end_addr   = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 24'h0;
        mem[0]    = 24'hDEAD00;
        mem[5]    = 24'h123456;
        mem[6]    = 24'hABCDEF;
        mem[7]    = 24'h000001;
        mem[8]    = 24'hFFFFFF;
        mem[16]   = 24'h0A0B0C;
        mem[20]   = 24'hC0FFEE;
        mem[21]   = 24'h00BEEF;
        mem[22]   = 24'h123ABC;
        mem[23]   = 24'h5A5A5A;
        mem[30]   = 24'h665544;
        mem[31]   = 24'h998877;
        mem[4095] = 24'h800001;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_address", {20'h0, mem_address}, 32'h0);
        check("rst_byteForTx", {24'h0, byteForTx}, 32'h0);
        check("rst_txByteStart", {31'h0, txByteStart}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_transmitted", {31'h0, mem_transmitted}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Four-word range
        base = pulses;
        push3(8'h56, 8'h34, 8'h12);
        push3(8'hEF, 8'hCD, 8'hAB);
        push3(8'h01, 8'h00, 8'h00);
        push3(8'hFF, 8'hFF, 8'hFF);
        start_xfer(12'd5, 12'd8);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_addr_start", {20'h0, mem_address}, 32'd5);
        wait_done("t1", 400);
        check("t1_pulse_count", pulses - base, 32'd12);
        check("t1_addr_end", {20'h0, mem_address}, 32'd8);

        // Single word and first-pulse latency
        base = pulses;
        push3(8'h0C, 8'h0B, 8'h0A);
        start_xfer(12'h010, 12'h010);
        check("t2_done_cleared", {31'h0, mem_transmitted}, 32'h0);
        check("t2_addr", {20'h0, mem_address}, 32'h010);
        @(negedge clk);
        check("t2_no_pulse_t1", {31'h0, txByteStart}, 32'h0);
        @(negedge clk);
        check("t2_no_pulse_t2", {31'h0, txByteStart}, 32'h0);
        @(negedge clk);
        check("t2_pulse_t3", {31'h0, txByteStart}, 32'h1);
        wait_done("t2", 200);
        check("t2_pulse_count", pulses - base, 32'd3);

        // Empty range
        base = pulses;
        start_xfer(12'd10, 12'd9);
        check("t3_done_cleared", {31'h0, mem_transmitted}, 32'h0);
        check("t3_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("t3_done_set", {31'h0, mem_transmitted}, 32'h1);
        check("t3_addr_held", {20'h0, mem_address}, 32'h010);
        repeat (6) @(negedge clk);
        check("t3_pulse_count", pulses - base, 32'd0);

        // Top address, no wrap
        base = pulses;
        push3(8'h01, 8'h00, 8'h80);
        start_xfer(12'd4095, 12'd4095);
        check("t4_addr_start", {20'h0, mem_address}, 32'd4095);
        wait_done("t4", 200);
        check("t4_addr_no_wrap", {20'h0, mem_address}, 32'd4095);
        check("t4_pulse_count", pulses - base, 32'd3);

        // Reset during the second byte, then full restart
        base = pulses;
        push3(8'hEE, 8'hFF, 8'hC0);
        push3(8'hEF, 8'hBE, 8'h00);
        push3(8'hBC, 8'h3A, 8'h12);
        push3(8'h5A, 8'h5A, 8'h5A);
        start_xfer(12'd20, 12'd23);
        wait_pulses("t5_second_pulse_seen", base + 2, 200);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_txByteStart", {31'h0, txByteStart}, 32'h0);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        check("t5_rst_mem_address", {20'h0, mem_address}, 32'h0);
        check("t5_rst_byteForTx", {24'h0, byteForTx}, 32'h0);
        check("t5_rst_mem_transmitted", {31'h0, mem_transmitted}, 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_no_pulse_after_abort", pulses - base, 32'd2);
        push3(8'hEE, 8'hFF, 8'hC0);
        push3(8'hEF, 8'hBE, 8'h00);
        push3(8'hBC, 8'h3A, 8'h12);
        push3(8'h5A, 8'h5A, 8'h5A);
        start_xfer(12'd20, 12'd23);
        check("t5_restart_addr", {20'h0, mem_address}, 32'd20);
        wait_done("t5", 600);
        check("t5_pulse_count", pulses - base, 32'd14);

        // Spurious start mid-transfer and a long ready stall
        base = pulses;
        push3(8'h44, 8'h55, 8'h66);
        push3(8'h77, 8'h88, 8'h99);
        start_xfer(12'd30, 12'd31);
        wait_pulses("t6_first_pulse_seen", base + 1, 200);
        tx_hold = 1'b1;
        start_xfer(12'd0, 12'd0);
        repeat (1000) @(negedge clk);
        check("t6_stall_pulses", pulses - base, 32'd1);
        check("t6_stall_busy", {31'h0, busy}, 32'h1);
        check("t6_stall_not_done", {31'h0, mem_transmitted}, 32'h0);
        tx_hold = 1'b0;
        wait_done("t6", 300);
        check("t6_pulse_count", pulses - base, 32'd6);
        check("t6_addr_end", {20'h0, mem_address}, 32'd31);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
